// File: rtl/stream_credit_tx.sv
// Credit-based stream transmitter: forwards valid/ready beats as valid-only link beats and
// tracks free slots in a remote FIFO of Depth entries so it can never overrun it.
module stream_credit_tx #(
    parameter int unsigned Depth    = 32'd8,
    parameter type         type_t   = logic,
    parameter bit          PipeOut  = 1'b1,
    parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  type_t               data_i,
    input  logic                valid_i,
    output logic                ready_o,
    output type_t               data_o,
    output logic                valid_o,
    input  logic                credit_i,
    output logic [CntWidth-1:0] credits_o,
    output logic                idle_o,
    output logic                err_o
);

    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

    if (Depth < 1) begin : gen_bad_depth
        $fatal(1, "stream_credit_tx: Depth must be >= 1");
    end

    logic [CntWidth-1:0] credits_q, credits_d;
    logic                err_q, err_d;
    logic                send;
    logic                credit_at_max;

    // ready_o is derived from registered state only, so a returned credit cannot enable a same-cycle send.
    assign ready_o       = (credits_q != '0);
    assign send          = valid_i & ready_o;
    assign credit_at_max = (credits_q == DepthCnt);

    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (flush_i) begin
            credits_d = DepthCnt;
        end else if (send && !credit_i) begin
            credits_d = credits_q - 1'b1;
        end else if (credit_i && !send) begin
            if (credit_at_max) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credits_q <= DepthCnt;
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    if (PipeOut) begin : gen_pipe
        type_t data_q;
        logic  valid_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (flush_i) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= send;
                if (send) begin
                    data_q <= data_i;
                end
            end
        end

        assign data_o  = data_q;
        assign valid_o = valid_q;
    end else begin : gen_comb
        // A send in the flush cycle is dropped, so it must not appear on the link either.
        assign data_o  = data_i;
        assign valid_o = send & ~flush_i;
    end

    assign credits_o = credits_q;
    assign err_o     = err_q;
    assign idle_o    = credit_at_max & ~valid_o;

endmodule
